pkt_data_src_switch: RTL
========================

PKT_DATA_SRC_SWITCH -- requirements
Module: pkt_data_src_switch

Interface
REQ-001 SHALL have parameter NUM_CH, default 24, number of ADC lanes.
REQ-002 SHALL have parameter DW, default 36, bits per lane.
REQ-003 SHALL have parameter GUARD_CYC, default 4, blanking cycles after a source switch (0 allowed).
REQ-004 SHALL have parameter SYNC_SWITCH, default 1; 1 = switch only at frame_sof, 0 = switch immediately.
REQ-005 SHALL have port clk  input  1  single clock for all logic.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port rf_self_test_mode  input  1  requested source: 1 = pkt_gen, 0 = ANA.
REQ-008 SHALL have port rf_ch_mask  input  NUM_CH  1 = lane forced to zero at output.
REQ-009 SHALL have port ana_adc_data  input  NUM_CH*DW  ADC lanes; lane i at bits [i*DW +: DW].
REQ-010 SHALL have port ana_adc_vld  input  1  ADC data valid.
REQ-011 SHALL have port pkt_gen_data  input  NUM_CH*DW  generator lanes, same packing.
REQ-012 SHALL have port pkt_gen_vld  input  1  generator data valid.
REQ-013 SHALL have port frame_sof  input  1  single-cycle frame-boundary pulse.
REQ-014 SHALL have port adc_data  output  NUM_CH*DW  registered selected lanes.
REQ-015 SHALL have port adc_data_vld  output  1  registered valid.
REQ-016 SHALL have port src_cur  output  1  source currently driving output (1 = pkt_gen).
REQ-017 SHALL have port switch_busy  output  1  high in WAIT or GUARD.
REQ-018 SHALL have port switch_cnt  output  16  completed switches, saturating.

Function
REQ-019 SHALL implement FSM states RUN, WAIT, GUARD.
REQ-020 RUN: if rf_self_test_mode != src_cur -> WAIT (SYNC_SWITCH=1) or directly to switch action (SYNC_SWITCH=0).
REQ-021 WAIT: rf_self_test_mode == src_cur -> RUN (request cancelled, no count); else frame_sof=1 -> switch action.
REQ-022 Switch action SHALL set src_cur <= rf_self_test_mode, increment switch_cnt (hold at 16'hFFFF), enter GUARD with counter = GUARD_CYC-1, or RUN if GUARD_CYC=0.
REQ-023 GUARD: counter decrements each cycle; at 0 -> RUN; rf_self_test_mode changes ignored until RUN.
REQ-024 frame_sof in RUN or GUARD SHALL have no effect.
REQ-025 Output latency SHALL be exactly 1 cycle from input to adc_data/adc_data_vld.
REQ-026 In RUN/WAIT: adc_data lane i <= rf_ch_mask[i] ? 0 : selected lane i; adc_data_vld <= selected vld; selection uses src_cur value before the edge.
REQ-027 In GUARD and in the cycle of the switch action: adc_data <= 0, adc_data_vld <= 0.
REQ-028 switch_busy SHALL be combinational from state (WAIT or GUARD).
REQ-029 Masked lanes SHALL output zero even when valid is high; mask is not registered before use.

Reset
REQ-030 On rst: state = RUN, src_cur = 0, guard counter = 0, switch_cnt = 0, adc_data = 0, adc_data_vld = 0.
REQ-031 rst asserted mid-WAIT or mid-GUARD SHALL abort the switch; after release src_cur = 0 and a pending mode=1 re-enters WAIT next cycle.

Verification
REQ-032 Defaults, mode=0, ana lane 0 = 36'h123456789, ana_vld=1 -> cycle later adc_data lane 0 = 36'h123456789, vld=1, src_cur=0.
REQ-033 Mode 0->1 at cycle 10, frame_sof at cycle 20 -> switch_busy 11..24, adc_data_vld=0 cycles 21..25 (switch + 4 guard), pkt_gen data from cycle 26, switch_cnt=1.
REQ-034 Mode 0->1 then back to 0 before frame_sof -> no switch, switch_cnt=0, ANA data uninterrupted.
REQ-035 SYNC_SWITCH=0, GUARD_CYC=0, mode toggled -> src_cur changes next cycle, exactly one cycle vld=0.
REQ-036 rf_ch_mask=24'h000005, all lanes 36'hFFFFFFFFF -> lanes 0 and 2 zero, others all-ones.
REQ-037 Force switch_cnt to 16'hFFFE, perform 3 switches -> switch_cnt ends 16'hFFFF.

Source files
------------

// File: rtl/pkt_data_src_switch.sv
// rtl/pkt_data_src_switch.sv - ADC / packet-generator source switch with frame-aligned hand-over and guard blanking
module pkt_data_src_switch #(
   parameter int NUM_CH      = 24,
   parameter int DW          = 36,
   parameter int GUARD_CYC   = 4,
   parameter int SYNC_SWITCH = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rf_self_test_mode,
   input  logic [NUM_CH-1:0]    rf_ch_mask,
   input  logic [NUM_CH*DW-1:0] ana_adc_data,
   input  logic                 ana_adc_vld,
   input  logic [NUM_CH*DW-1:0] pkt_gen_data,
   input  logic                 pkt_gen_vld,
   input  logic                 frame_sof,
   output logic [NUM_CH*DW-1:0] adc_data,
   output logic                 adc_data_vld,
   output logic                 src_cur,
   output logic                 switch_busy,
   output logic [15:0]          switch_cnt
);

   typedef enum logic [1:0] {RUN, WAIT, GUARD} state_t;

   localparam int GW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
   localparam logic [GW-1:0] GUARD_INIT = (GUARD_CYC > 0) ? GW'(GUARD_CYC - 1) : '0;

   state_t               state, state_nxt;
   logic                 src_nxt;
   logic [GW-1:0]        guard_cnt, guard_nxt;
   logic                 do_switch;
   logic                 blank;
   logic [NUM_CH*DW-1:0] data_nxt;
   logic                 vld_nxt;

   always_comb begin
      state_nxt = state;
      src_nxt   = src_cur;
      guard_nxt = guard_cnt;
      do_switch = 1'b0;
      case (state)
         RUN: begin
            if (rf_self_test_mode != src_cur) begin
               if (SYNC_SWITCH != 0) state_nxt = WAIT;
               else                  do_switch = 1'b1;
            end
         end
         WAIT: begin
            if (rf_self_test_mode == src_cur) state_nxt = RUN;
            else if (frame_sof)               do_switch = 1'b1;
         end
         GUARD: begin
            if (guard_cnt == '0) state_nxt = RUN;
            else                 guard_nxt = guard_cnt - 1'b1;
         end
         default: state_nxt = RUN;
      endcase
      if (do_switch) begin
         src_nxt = rf_self_test_mode;
         if (GUARD_CYC == 0) begin
            state_nxt = RUN;
         end else begin
            state_nxt = GUARD;
            guard_nxt = GUARD_INIT;
         end
      end
   end

   // Output is blanked for the switch cycle itself and throughout the guard window.
   assign blank = (state == GUARD) || do_switch;

   always_comb begin
      data_nxt = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (!(rf_ch_mask[i] || blank))
            data_nxt[i*DW +: DW] = src_cur ? pkt_gen_data[i*DW +: DW] : ana_adc_data[i*DW +: DW];
      end
      vld_nxt = blank ? 1'b0 : (src_cur ? pkt_gen_vld : ana_adc_vld);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= RUN;
         src_cur      <= 1'b0;
         guard_cnt    <= '0;
         switch_cnt   <= '0;
         adc_data     <= '0;
         adc_data_vld <= 1'b0;
      end else begin
         state        <= state_nxt;
         src_cur      <= src_nxt;
         guard_cnt    <= guard_nxt;
         adc_data     <= data_nxt;
         adc_data_vld <= vld_nxt;
         if (do_switch && (switch_cnt != 16'hFFFF))
            switch_cnt <= switch_cnt + 16'd1;
      end
   end

   assign switch_busy = (state == WAIT) || (state == GUARD);

endmodule
